param_filter_cache: RTL
=======================

Name: param_filter_cache

Overview:
- Parametrised successor to the fixed four-vector filter memory manager.
- Loads NUM_VEC filter vectors of VEC_LEN elements each from single-port filter memory into an internal register cache, then streams one element of every vector per cycle, in parallel, to the convolution datapath.
- Adds explicit reload, pause (en low) during fill, configurable base address and vector stride, and a done/busy status the old block lacked.

Parameters:
- DATA_W, 16, element width in bits.
- NUM_VEC, 4, number of filter vectors cached and streamed in parallel (1..16).
- VEC_LEN, 16, elements per vector (power of two, 2..256).
- ADDR_W, 9, filter memory address width.
- BASE_ADDR, 0, memory address of element 0 of vector 0.
- VEC_STRIDE, 16, address distance between vector starts (>= VEC_LEN).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-high reset.
- en  in  1  advance enable; gates fill reads and stream steps.
- reload  in  1  single-cycle pulse; (re)starts a fill from vector 0, element 0.
- vector_element  in  DATA_W  read data from memory, valid one cycle after memory_enable.
- vector_memory_address  out  ADDR_W  memory read address.
- memory_enable  out  1  memory read strobe.
- memory_write  out  1  tied 0.
- b_elements_ready  out  1  b_elements holds a valid set this cycle.
- b_elements  out  NUM_VEC*DATA_W  element e of vector v at bits [v*DATA_W +: DATA_W].
- element_index  out  clog2(VEC_LEN)  index e of the set currently on b_elements.
- last_element  out  1  high with b_elements_ready when element_index == VEC_LEN-1.
- cached  out  1  all vectors loaded.
- busy  out  1  fill in progress.

Behaviour:
- Reset (clear high, async): state IDLE; all outputs 0; counters 0; cache contents don't-care; cached = 0.
- States:
  - IDLE: waits for reload.
  - FILL: issues reads.
  - DRAIN: waits for the last read data.
  - STREAM: outputs element sets.
- IDLE -> FILL on reload.
- FILL:
  - Each cycle with en = 1, drive memory_enable = 1 and vector_memory_address = BASE_ADDR + v*VEC_STRIDE + e (truncated to ADDR_W).
  - Then advance e; on e wrap, advance v.
  - memory_enable and vector_memory_address are combinational from state/counters.
  - en = 0 holds the counters and drives memory_enable = 0 (pause).
- Capture: a read-pending flag and slot (v,e) are registered with each issued read. vector_element is written into cache[v][e] on the next edge.
- After issuing v = NUM_VEC-1, e = VEC_LEN-1, go to DRAIN. DRAIN -> STREAM on the next edge, once the final word is captured; cached rises then, busy falls. busy = 1 in FILL and DRAIN.
- Total fill = NUM_VEC*VEC_LEN enabled cycles + 1.
- STREAM:
  - Each en = 1 cycle registers cache[*][e] to b_elements, element_index <= e, b_elements_ready <= 1, then e <= (e+1) mod VEC_LEN.
  - Latency: en edge to b_elements_ready = 1 cycle.
  - en = 0: b_elements_ready <= 0, b_elements and element_index hold.
  - Streaming wraps indefinitely (same filter reused per output pixel).
- reload while in FILL or DRAIN: restart at v = e = 0, discard the in-flight capture, cached stays 0.
- reload while in STREAM: cached <= 0, b_elements_ready <= 0, go to FILL. Reload wins over a simultaneous en step.
- memory_enable is never high outside FILL. No writes are issued.

Test Plan:
- Reset mid-fill: assert clear after 10 fill reads -> all outputs 0 immediately (async); after release, state IDLE, no memory_enable until reload.
- Default params, memory[a] = 0x100 + a, reload then en = 1 continuously -> addresses 0..63 in order, 64 consecutive memory_enable cycles; cached rises 65 cycles after first read; first set b_elements v0..v3 = 0x100, 0x110, 0x120, 0x130, element_index 0.
- Stream wrap: continue en -> element_index 0..15, last_element high on 15 with v3 = 0x13F, next set element_index 0 with v0 = 0x100.
- Fill pause: toggle en 1/0 every cycle during fill -> same 64 addresses in order, memory_enable only on en-high cycles, cache contents identical to the continuous case.
- Reload in STREAM, memory rewritten to 0x200 + a -> cached drops, b_elements_ready 0, refill; first new set v0 = 0x200, v3 = 0x230.
- NUM_VEC = 2, VEC_LEN = 8, BASE_ADDR = 32, VEC_STRIDE = 16 -> fill addresses 32..39 then 48..55; first set v0 = mem[32], v1 = mem[48].

Source files
------------

// File: rtl/param_filter_cache.sv
// Filter cache: fills NUM_VEC x VEC_LEN elements from single-port memory into registers,
// then streams element e of every vector in parallel on each enabled cycle.
module param_filter_cache #(
  parameter int DATA_W     = 16,
  parameter int NUM_VEC    = 4,
  parameter int VEC_LEN    = 16,
  parameter int ADDR_W     = 9,
  parameter int BASE_ADDR  = 0,
  parameter int VEC_STRIDE = 16
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       en,
  input  logic                       reload,
  input  logic [DATA_W-1:0]          vector_element,
  output logic [ADDR_W-1:0]          vector_memory_address,
  output logic                       memory_enable,
  output logic                       memory_write,
  output logic                       b_elements_ready,
  output logic [NUM_VEC*DATA_W-1:0]  b_elements,
  output logic [$clog2(VEC_LEN)-1:0] element_index,
  output logic                       last_element,
  output logic                       cached,
  output logic                       busy
);
  localparam int EW = $clog2(VEC_LEN);
  localparam int VW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam logic [EW-1:0] E_LAST = EW'(VEC_LEN - 1);
  localparam logic [VW-1:0] V_LAST = VW'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    DRAIN  = 2'd2,
    STREAM = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [VW-1:0]     vec_cnt;
  logic [EW-1:0]     elem_cnt;
  logic              pend;
  logic [VW-1:0]     pend_vec;
  logic [EW-1:0]     pend_elem;
  logic [DATA_W-1:0] cache [NUM_VEC][VEC_LEN];
  logic              fill_step;
  logic              fill_done;
  logic              stream_step;

  assign fill_step   = (state == FILL) && en;
  assign fill_done   = fill_step && (vec_cnt == V_LAST) && (elem_cnt == E_LAST);
  assign stream_step = (state == STREAM) && en;
  assign memory_write = 1'b0;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // reload restarts the fill from any state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (reload) state_next = FILL;  else state_next = IDLE;
      FILL:    if (reload) state_next = FILL;  else if (fill_done) state_next = DRAIN; else state_next = FILL;
      DRAIN:   if (reload) state_next = FILL;  else state_next = STREAM;
      STREAM:  if (reload) state_next = FILL;  else state_next = STREAM;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    memory_enable         = 1'b0;
    vector_memory_address = {ADDR_W{1'b0}};
    busy                  = 1'b0;
    if (state == FILL) begin
      memory_enable         = en;
      vector_memory_address = ADDR_W'(32'(BASE_ADDR) + 32'(vec_cnt) * 32'(VEC_STRIDE) + 32'(elem_cnt));
      busy                  = 1'b1;
    end else if (state == DRAIN) begin
      busy = 1'b1;
    end else begin
      busy = 1'b0;
    end
  end

  // A full fill leaves both counters wrapped to zero, so streaming starts at element 0
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      vec_cnt   <= {VW{1'b0}};
      elem_cnt  <= {EW{1'b0}};
      pend      <= 1'b0;
      pend_vec  <= {VW{1'b0}};
      pend_elem <= {EW{1'b0}};
    end else if (reload) begin
      vec_cnt  <= {VW{1'b0}};
      elem_cnt <= {EW{1'b0}};
      pend     <= 1'b0;
    end else begin
      pend      <= fill_step;
      pend_vec  <= vec_cnt;
      pend_elem <= elem_cnt;
      if (fill_step || stream_step) begin
        elem_cnt <= elem_cnt + EW'(1);
      end
      if (fill_step && (elem_cnt == E_LAST)) begin
        vec_cnt <= (vec_cnt == V_LAST) ? {VW{1'b0}} : vec_cnt + VW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (pend && !reload) begin
      cache[pend_vec][pend_elem] <= vector_element;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      b_elements_ready <= 1'b0;
      b_elements       <= {(NUM_VEC*DATA_W){1'b0}};
      element_index    <= {EW{1'b0}};
      last_element     <= 1'b0;
      cached           <= 1'b0;
    end else if (reload) begin
      b_elements_ready <= 1'b0;
      last_element     <= 1'b0;
      cached           <= 1'b0;
    end else begin
      if (stream_step) begin
        b_elements_ready <= 1'b1;
        element_index    <= elem_cnt;
        last_element     <= (elem_cnt == E_LAST);
        for (int v = 0; v < NUM_VEC; v++) begin
          b_elements[v*DATA_W +: DATA_W] <= cache[v][elem_cnt];
        end
      end else begin
        b_elements_ready <= 1'b0;
        last_element     <= 1'b0;
      end
      if (state == DRAIN) begin
        cached <= 1'b1;
      end else begin
        cached <= cached;
      end
    end
  end
endmodule
